riscv_pipe_fifo: RTL

Parametrised elastic buffer between two RISC-V pipeline stages, using the rdy/ack handshake on both sides. It generalises the single-entry stage register to DATA_W bits and DEPTH entries. It registers the upstream ack so that no combinational path runs from downstream ack to upstream ack, and it adds a synchronous pipeline flush for branch and exception kills. It sits between any producer/consumer stage pair, for example ex→mem or mem→wb.

---
 rtl/riscv_pipe_fifo.sv | 98 +++++++++
 1 files changed

// File: rtl/riscv_pipe_fifo.sv
// riscv_pipe_fifo: elastic rdy/ack buffer between two RISC-V pipeline stages.
// It is a DEPTH-entry circular queue with a synchronous flush. in_ack comes from
// the registered occupancy only, so no combinational path runs from out_ack to in_ack.
// Optional zero-latency bypass when empty: define RISCV_PIPE_BYPASS_EN.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (priority over flush)
//   flush     discard all stored and in-flight entries at the next edge
//   in_rdy    upstream beat valid          in_ack    buffer can accept (= !full)
//   in_data   upstream payload
//   out_rdy   head beat valid              out_ack   downstream consumes head
//   out_data  head-of-queue payload        count     occupancy 0..DEPTH
module riscv_pipe_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_rdy,
  output logic              in_ack,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_rdy,
  input  logic              out_ack,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty, push, pop, wr_en, rd_en;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign in_ack = !full;
  assign push   = in_rdy && in_ack;
  assign count  = count_q;

`ifdef RISCV_PIPE_BYPASS_EN
  // Empty buffer forwards the upstream beat in the same cycle.
  logic bypass;
  assign bypass   = empty && in_rdy;
  assign out_rdy  = (!empty || in_rdy) && !flush;
  assign out_data = bypass ? in_data : mem_q[rd_ptr_q];
  assign pop      = out_rdy && out_ack;
  // A bypassed beat that is consumed immediately never touches storage.
  assign wr_en    = push && !(bypass && pop);
  assign rd_en    = pop && !empty;
`else
  assign out_rdy  = !empty && !flush;
  assign out_data = mem_q[rd_ptr_q];
  assign pop      = out_rdy && out_ack;
  assign wr_en    = push;
  assign rd_en    = pop;
`endif

  // Next-state pointers and occupancy; flush zeroes everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en && !flush) mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule
